motoro3_step_sequencer: RTL and testbench
=========================================

Name: motoro3_step_sequencer

Overview:
- Commutation scheduler for the 3-phase motor PWM datapath.
- Generates the step index sgStep (0..11), the per-step down-counter m3cnt, the step-boundary strobes m3cntFirst1/2 and m3cntLast1/2, pwmActive1 and pwmLastStep1.
- Runs a start/stop handshake with the register block.
- Supports a finite step count or continuous rotation, in either direction.

Parameters:
- CNT_W, 25, width of m3cnt and step-length register.
- STEP_N, 12, steps per electrical revolution; sgStep wraps at STEP_N-1.
- RUN_W, 16, width of the run-step counter.
- LEN_MIN, 4, minimum effective step length in clocks.

Ports:
- clk  in  1  10 MHz system clock; all registers update on the falling edge.
- nRst  in  1  reset, asynchronous, active-low.
- start  in  1  one-clock start request.
- stop  in  1  one-clock graceful-stop request.
- m3r_dir  in  1  1 = forward (0,1..11,0), 0 = reverse (0,11,10..).
- m3r_stepLen  in  CNT_W  clocks per step; sampled at each step boundary.
- m3r_runSteps  in  RUN_W  steps to run; 0 = continuous.
- sgStep  out  4  current step index.
- m3cnt  out  CNT_W  clocks remaining in the step (counts down to 0).
- m3cntFirst2  out  1  first clock of the step.
- m3cntFirst1  out  1  second clock of the step.
- m3cntLast2  out  1  second-to-last clock of the step (m3cnt==1).
- m3cntLast1  out  1  last clock of the step (m3cnt==0).
- pwmActive1  out  1  PWM datapath enabled.
- pwmLastStep1  out  1  current step is the final step.
- busy  out  1  state is not IDLE.
- done  out  1  one-clock pulse when a run finishes.

Behaviour:
- Reset values: sgStep=0, m3cnt=0, all strobes 0, pwmActive1=0, pwmLastStep1=0, busy=0, done=0, FSM=IDLE, run counter=0.
- States: IDLE, ARM, RUN, STOPPING.
- IDLE, start=1 and stop=0:
  - go to ARM next edge.
  - sgStep<=0.
  - latch lenEff = max(m3r_stepLen, LEN_MIN).
  - latch remaining run steps from m3r_runSteps.
- IDLE, start and stop together: stay IDLE.
- ARM (exactly 1 clock):
  - pwmActive1=1; m3cnt<=lenEff-1.
  - go to RUN, or to IDLE if stop=1 (no done pulse).
- Start-to-RUN latency: start at edge N gives ARM at N+1 and RUN at N+2, with m3cntFirst2=1 at N+2.
- RUN/STOPPING:
  - m3cnt decrements each clock.
  - Strobes decode combinationally from m3cnt and lenEff, gated by RUN|STOPPING:
    - First2: m3cnt==lenEff-1
    - First1: m3cnt==lenEff-2
    - Last2: m3cnt==1
    - Last1: m3cnt==0
- Step boundary (m3cnt==0 in RUN):
  - sgStep advances per m3r_dir with wrap at 0/STEP_N-1.
  - re-sample lenEff; m3cnt<=new lenEff-1.
  - decrement the run counter if finite.
- Finite run: pwmLastStep1=1 for the whole step in which the run counter equals 1. At the boundary of that step:
  - go to IDLE.
  - pwmActive1<=0; done pulses 1 clock.
  - sgStep holds its last value; m3cnt<=0.
- stop in RUN:
  - go to STOPPING next edge; pwmLastStep1=1 from that edge.
  - the current step completes.
  - at m3cnt==0: go to IDLE and pulse done, with the same exit values as a finite run.
- stop in STOPPING or IDLE: ignored.
- start while busy: ignored.
- Run counter: m3r_runSteps=1 gives a single step with pwmLastStep1 high throughout.
- Continuous mode: the run counter is never decremented and pwmLastStep1 stays 0 until stop.
- Changes to m3r_stepLen mid-step take effect only at the next boundary.
- m3r_dir is sampled at each boundary.
- nRst asserted mid-run: all outputs take reset values immediately (asynchronous); no done pulse.

Decomposition:
- Shared package motoro3_pkg:
  - FSM state encoding (IDLE=0, ARM=1, RUN=2, STOPPING=3).
  - STEP_N, LEN_MIN, and step constants 0/5/6/11 (phase-half boundaries used by the datapath accumulators).
- One sub-module, motoro3_step_timer:
  - m3cnt down-counter with boundary reload and lenEff latch.
  - First/Last strobe decode.
  - outputs a stepEnd pulse to the FSM.

Test Plan:
- Basic run: stepLen=10, runSteps=3, dir=1, start pulse.
  - RUN 2 clocks after start.
  - sgStep 0,1,2, 10 clocks each.
  - First2 at m3cnt=9, First1 at 8, Last2 at 1, Last1 at 0.
  - pwmLastStep1 high only during step 2.
  - done pulse 1 clock after the last Last1; pwmActive1=0, sgStep=2.
- Wrap/reverse: stepLen=4, runSteps=14, dir=0.
  - sgStep sequence 0,11,10,...,1,0,11.
  - done after 56 clocks of RUN.
- Graceful stop: continuous mode, stepLen=20, stop pulse at m3cnt=12 in step 3.
  - pwmLastStep1 rises next clock.
  - step 3 completes; IDLE/done at m3cnt==0.
  - sgStep stays 3.
- Clamp and length change:
  - stepLen=2 gives 4-clock steps.
  - changing stepLen 8->16 mid-step 1: step 1 stays 8 clocks, step 2 is 16.
- Handshake edges:
  - start+stop in IDLE: stays IDLE.
  - stop during ARM: IDLE, no done, pwmActive1 high for 1 clock only.
  - start during RUN: ignored.
- Async reset: nRst low mid-step 5.
  - all outputs reset immediately, no done.
  - a later start restarts at sgStep=0.

Source files
------------

// File: rtl/motoro3_pkg.sv
`default_nettype none
// ============================================================================
// Module      : motoro3_pkg
// Description : Shared types and constants for the 3-phase step sequencer
//               and the PWM datapath that consumes its step index.
// Revision    : 1.0 - initial release
// ============================================================================
package motoro3_pkg;

   // Sequencer FSM encoding
   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      ARM      = 2'd1,
      RUN      = 2'd2,
      STOPPING = 2'd3
   } seq_state_t;

   localparam int STEP_N  = 12;   // steps per electrical revolution
   localparam int LEN_MIN = 4;    // shortest step that keeps all four strobes distinct

   // Phase-half boundaries used by the datapath accumulators
   localparam logic [3:0] STEP_0  = 4'd0;
   localparam logic [3:0] STEP_5  = 4'd5;
   localparam logic [3:0] STEP_6  = 4'd6;
   localparam logic [3:0] STEP_11 = 4'd11;

   // Next step index with wrap at 0 / n-1; fwd=1 counts up
   function automatic logic [3:0] step_next(input logic [3:0] cur, input logic fwd, input int n);
      logic [3:0] top_step;
      top_step = 4'(n - 1);
      if (fwd)
         return (cur == top_step) ? STEP_0 : cur + 4'd1;
      else
         return (cur == STEP_0) ? top_step : cur - 4'd1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/motoro3_step_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : motoro3_step_sequencer_if
// Description : Register-block <-> step sequencer connection: start/stop
//               handshake, run configuration and step/strobe status.
// Revision    : 1.0 - initial release
// ============================================================================
interface motoro3_step_sequencer_if #(
   parameter int CNT_W = 25,
   parameter int RUN_W = 16
);
   logic             start;
   logic             stop;
   logic             m3r_dir;
   logic [CNT_W-1:0] m3r_stepLen;
   logic [RUN_W-1:0] m3r_runSteps;
   logic [3:0]       sgStep;
   logic [CNT_W-1:0] m3cnt;
   logic             m3cntFirst2;
   logic             m3cntFirst1;
   logic             m3cntLast2;
   logic             m3cntLast1;
   logic             pwmActive1;
   logic             pwmLastStep1;
   logic             busy;
   logic             done;

   // Register block side
   modport master (
      output start, stop, m3r_dir, m3r_stepLen, m3r_runSteps,
      input  sgStep, m3cnt, m3cntFirst2, m3cntFirst1, m3cntLast2, m3cntLast1,
      input  pwmActive1, pwmLastStep1, busy, done
   );

   // Sequencer side
   modport slave (
      input  start, stop, m3r_dir, m3r_stepLen, m3r_runSteps,
      output sgStep, m3cnt, m3cntFirst2, m3cntFirst1, m3cntLast2, m3cntLast1,
      output pwmActive1, pwmLastStep1, busy, done
   );
endinterface
`default_nettype wire

// File: rtl/motoro3_step_timer.sv
`default_nettype none
// ============================================================================
// Module      : motoro3_step_timer
// Description : Per-step down-counter with boundary reload, clamped step
//               length latch and First/Last strobe decode.
// Revision    : 1.0 - initial release
// ============================================================================
module motoro3_step_timer #(
   parameter int CNT_W   = 25,
   parameter int LEN_MIN = motoro3_pkg::LEN_MIN
) (
   input  logic             clk,
   input  logic             nRst,
   input  logic             sample,     // run accepted: latch the first step length
   input  logic             load,       // leaving ARM: start the first step
   input  logic             active,     // RUN or STOPPING
   input  logic             finish,     // this boundary ends the run
   input  logic [CNT_W-1:0] step_len,
   output logic [CNT_W-1:0] m3cnt,
   output logic             first2,
   output logic             first1,
   output logic             last2,
   output logic             last1,
   output logic             step_end
);
   localparam logic [CNT_W-1:0] LEN_FLOOR = CNT_W'(LEN_MIN);
   localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
   localparam logic [CNT_W-1:0] TWO       = CNT_W'(2);

   logic [CNT_W-1:0] len_eff;
   logic [CNT_W-1:0] len_new;

   assign len_new  = (step_len < LEN_FLOOR) ? LEN_FLOOR : step_len;
   assign step_end = active && (m3cnt == '0);

   // Strobes compare against the length latched for the step in progress
   always_comb begin
      first2 = active && (m3cnt == len_eff - ONE);
      first1 = active && (m3cnt == len_eff - TWO);
      last2  = active && (m3cnt == ONE);
      last1  = active && (m3cnt == '0);
   end

   // Length latch and down-counter; a new length only lands at a boundary
   always_ff @(negedge clk or negedge nRst) begin
      if (!nRst) begin
         len_eff <= LEN_FLOOR;
         m3cnt   <= '0;
      end else begin
         if (sample || (step_end && !finish))
            len_eff <= len_new;

         if (load)
            m3cnt <= len_eff - ONE;
         else if (step_end)
            m3cnt <= finish ? '0 : len_new - ONE;
         else if (active)
            m3cnt <= m3cnt - ONE;
      end
   end
endmodule
`default_nettype wire

// File: rtl/motoro3_step_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : motoro3_step_sequencer
// Description : Commutation scheduler for the 3-phase PWM datapath: step
//               index, step timer, start/stop handshake, finite or
//               continuous rotation in either direction.
// Revision    : 1.0 - initial release
// ============================================================================
module motoro3_step_sequencer
   import motoro3_pkg::*;
#(
   parameter int CNT_W   = 25,
   parameter int STEP_N  = motoro3_pkg::STEP_N,
   parameter int RUN_W   = 16,
   parameter int LEN_MIN = motoro3_pkg::LEN_MIN
) (
   input  logic                      clk,
   input  logic                      nRst,
   motoro3_step_sequencer_if.slave   bus
);
   localparam logic [RUN_W-1:0] RUN_ONE = RUN_W'(1);

   seq_state_t       state;
   seq_state_t       next_state;
   logic [3:0]       sg_step;
   logic [RUN_W-1:0] run_cnt;       // 0 means continuous rotation
   logic             pwm_active;
   logic             done_q;
   logic             accept;
   logic             arm_go;
   logic             abort;
   logic             finish;
   logic             active;
   logic             step_end;

   assign active = (state == RUN) || (state == STOPPING);

   motoro3_step_timer #(
      .CNT_W   (CNT_W),
      .LEN_MIN (LEN_MIN)
   ) u_timer (
      .clk      (clk),
      .nRst     (nRst),
      .sample   (accept),
      .load     (arm_go),
      .active   (active),
      .finish   (finish),
      .step_len (bus.m3r_stepLen),
      .m3cnt    (bus.m3cnt),
      .first2   (bus.m3cntFirst2),
      .first1   (bus.m3cntFirst1),
      .last2    (bus.m3cntLast2),
      .last1    (bus.m3cntLast1),
      .step_end (step_end)
   );

   // Next-state and transition qualifiers
   always_comb begin
      next_state = state;
      accept     = 1'b0;
      arm_go     = 1'b0;
      abort      = 1'b0;
      finish     = 1'b0;
      case (state)
         IDLE: begin
            if (bus.start && !bus.stop) begin
               next_state = ARM;
               accept     = 1'b1;
            end
         end
         ARM: begin
            if (bus.stop) begin
               next_state = IDLE;
               abort      = 1'b1;
            end else begin
               next_state = RUN;
               arm_go     = 1'b1;
            end
         end
         RUN: begin
            if (step_end && (run_cnt == RUN_ONE)) begin
               next_state = IDLE;
               finish     = 1'b1;
            end else if (bus.stop) begin
               next_state = STOPPING;
            end
         end
         STOPPING: begin
            if (step_end) begin
               next_state = IDLE;
               finish     = 1'b1;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   // State register
   always_ff @(negedge clk or negedge nRst) begin
      if (!nRst)
         state <= IDLE;
      else
         state <= next_state;
   end

   // Step index, run counter, PWM enable and done pulse
   always_ff @(negedge clk or negedge nRst) begin
      if (!nRst) begin
         sg_step    <= STEP_0;
         run_cnt    <= '0;
         pwm_active <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         done_q <= finish;
         if (accept) begin
            sg_step    <= STEP_0;
            run_cnt    <= bus.m3r_runSteps;
            pwm_active <= 1'b1;
         end else if (abort || finish) begin
            // sgStep holds the last step so the datapath can see where it stopped
            pwm_active <= 1'b0;
            run_cnt    <= '0;
         end else if (step_end) begin
            sg_step <= step_next(sg_step, bus.m3r_dir, STEP_N);
            if (run_cnt != '0)
               run_cnt <= run_cnt - RUN_ONE;
         end
      end
   end

   assign bus.sgStep       = sg_step;
   assign bus.pwmActive1   = pwm_active;
   assign bus.pwmLastStep1 = ((state == RUN) && (run_cnt == RUN_ONE)) || (state == STOPPING);
   assign bus.busy         = (state != IDLE);
   assign bus.done         = done_q;
endmodule
`default_nettype wire

// File: tb/tb_motoro3_step_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_motoro3_step_sequencer
// Description : Scoreboard bench for the step sequencer: directed runs push
//               expected per-clock traces, a monitor pops and compares on
//               every clock where the sequencer is busy or signals done.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_motoro3_step_sequencer;
   localparam int CNT_W = 25;
   localparam int RUN_W = 16;

   typedef struct packed {
      logic [3:0]       sg;
      logic [CNT_W-1:0] cnt;
      logic             f2, f1, l2, l1, last, pwm, busy, done;
   } obs_t;

   logic clk  = 1'b0;
   logic nRst = 1'b0;
   int   errors = 0;
   int   checks = 0;
   obs_t exp_q[$];

   motoro3_step_sequencer_if #(.CNT_W(CNT_W), .RUN_W(RUN_W)) bus();

   motoro3_step_sequencer #(
      .CNT_W(CNT_W), .STEP_N(12), .RUN_W(RUN_W), .LEN_MIN(4)
   ) dut (
      .clk  (clk),
      .nRst (nRst),
      .bus  (bus.slave)
   );

   // 10 MHz clock
   always #50 clk = ~clk;

   function automatic obs_t mk(input int sg, input int cnt, input int len, input bit act,
                               input bit last, input bit pwm, input bit bsy, input bit dn);
      obs_t o;
      o.sg   = 4'(sg);
      o.cnt  = CNT_W'(cnt);
      o.f2   = act && (cnt == len - 1);
      o.f1   = act && (cnt == len - 2);
      o.l2   = act && (cnt == 1);
      o.l1   = act && (cnt == 0);
      o.last = last;
      o.pwm  = pwm;
      o.busy = bsy;
      o.done = dn;
      return o;
   endfunction

   function automatic void push_arm();
      exp_q.push_back(mk(0, 0, 0, 0, 0, 1, 1, 0));
   endfunction

   function automatic void push_cycles(input int sg, input int len, input int hi, input int lo, input bit last);
      for (int c = hi; c >= lo; c--)
         exp_q.push_back(mk(sg, c, len, 1, last, 1, 1, 0));
   endfunction

   function automatic void push_step(input int sg, input int len, input bit last);
      push_cycles(sg, len, len - 1, 0, last);
   endfunction

   function automatic void push_done(input int sg);
      exp_q.push_back(mk(sg, 0, 0, 0, 0, 0, 0, 1));
   endfunction

   // Monitor: one comparison per clock in which the sequencer presents output
   initial begin
      obs_t got;
      obs_t want;
      forever begin
         @(posedge clk);
         if (nRst && (bus.busy || bus.done)) begin
            got = '{bus.sgStep, bus.m3cnt, bus.m3cntFirst2, bus.m3cntFirst1, bus.m3cntLast2,
                    bus.m3cntLast1, bus.pwmLastStep1, bus.pwmActive1, bus.busy, bus.done};
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL trace_extra: got sg=%0d cnt=%0d flags=%b, required no activity",
                        got.sg, got.cnt, got[7:0]);
            end else begin
               want = exp_q.pop_front();
               if (got !== want) begin
                  errors++;
                  $display("FAIL trace: got sg=%0d cnt=%0d flags(f2f1l2l1 last pwm busy done)=%b, required sg=%0d cnt=%0d flags=%b",
                           got.sg, got.cnt, got[7:0], want.sg, want.cnt, want[7:0]);
               end
            end
         end
      end
   end

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %0d, required %0d", name, got, want);
      end
   endtask

   task automatic pulse_start();
      bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
   endtask

   // Returns at the posedge where the DUT shows the given step/count
   task automatic wait_at(input int sg, input int cnt, input int budget);
      bit hit = 0;
      for (int n = 0; n < budget && !hit; n++) begin
         @(posedge clk);
         hit = (bus.sgStep == 4'(sg)) && (bus.m3cnt == CNT_W'(cnt));
      end
      checks++;
      if (!hit) begin
         errors++;
         $display("FAIL wait_at: got no sg=%0d cnt=%0d within %0d clocks, required reached", sg, cnt, budget);
      end
   endtask

   task automatic drain(input string name, input int budget);
      int n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         @(posedge clk); #1;
         n++;
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL %s: got %0d expected clocks never observed, required 0", name, exp_q.size());
         exp_q.delete();
      end
      repeat (2) begin @(posedge clk); #1; end
   endtask

   task automatic chk_reset_vals(input string name);
      chk({name, "_sg"},    bus.sgStep, 0);
      chk({name, "_cnt"},   bus.m3cnt, 0);
      chk({name, "_strb"},  {bus.m3cntFirst2, bus.m3cntFirst1, bus.m3cntLast2, bus.m3cntLast1}, 0);
      chk({name, "_pwm"},   bus.pwmActive1, 0);
      chk({name, "_last"},  bus.pwmLastStep1, 0);
      chk({name, "_busy"},  bus.busy, 0);
      chk({name, "_done"},  bus.done, 0);
   endtask

   initial begin
      int s;
      bus.start = 1'b0;  bus.stop = 1'b0;  bus.m3r_dir = 1'b1;
      bus.m3r_stepLen = CNT_W'(10);  bus.m3r_runSteps = RUN_W'(3);
      repeat (2) @(posedge clk);
      #1;
      chk_reset_vals("reset");
      nRst = 1'b1;
      @(posedge clk); #1;

      // Basic run: 3 forward steps of 10 clocks
      push_arm();
      push_step(0, 10, 0); push_step(1, 10, 0); push_step(2, 10, 1);
      push_done(2);
      pulse_start();
      drain("basic", 100);
      chk("basic_sg_hold", bus.sgStep, 2);

      // Reverse with wrap: 14 steps of 4 clocks
      bus.m3r_dir = 1'b0; bus.m3r_stepLen = CNT_W'(4); bus.m3r_runSteps = RUN_W'(14);
      push_arm();
      s = 0;
      for (int i = 0; i < 14; i++) begin
         push_step(s, 4, i == 13);
         s = (s == 0) ? 11 : s - 1;
      end
      push_done(11);
      pulse_start();
      drain("reverse", 100);

      // Graceful stop in continuous mode at m3cnt=12 of step 3
      bus.m3r_dir = 1'b1; bus.m3r_stepLen = CNT_W'(20); bus.m3r_runSteps = RUN_W'(0);
      push_arm();
      push_step(0, 20, 0); push_step(1, 20, 0); push_step(2, 20, 0);
      push_cycles(3, 20, 19, 12, 0); push_cycles(3, 20, 11, 0, 1);
      push_done(3);
      pulse_start();
      wait_at(3, 12, 200);
      #1 bus.stop = 1'b1;
      @(posedge clk); #1 bus.stop = 1'b0;
      drain("graceful_stop", 100);
      chk("stop_sg_hold", bus.sgStep, 3);

      // Clamp: a length of 2 runs as 4
      bus.m3r_stepLen = CNT_W'(2); bus.m3r_runSteps = RUN_W'(2);
      push_arm(); push_step(0, 4, 0); push_step(1, 4, 1); push_done(1);
      pulse_start();
      drain("clamp", 50);

      // Length change 8->16 mid step 1 lands on step 2
      bus.m3r_stepLen = CNT_W'(8); bus.m3r_runSteps = RUN_W'(3);
      push_arm(); push_step(0, 8, 0); push_step(1, 8, 0); push_step(2, 16, 1); push_done(2);
      pulse_start();
      wait_at(1, 4, 50);
      #1 bus.m3r_stepLen = CNT_W'(16);
      drain("len_change", 100);

      // start+stop together in IDLE is ignored
      bus.start = 1'b1; bus.stop = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0; bus.stop = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk("startstop_busy", bus.busy, 0);
         @(posedge clk); #1;
      end

      // stop during ARM: back to IDLE, no done
      bus.m3r_stepLen = CNT_W'(10);
      push_arm();
      bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0; bus.stop = 1'b1;
      @(posedge clk); #1;
      bus.stop = 1'b0;
      chk("arm_stop_pwm", bus.pwmActive1, 0);
      chk("arm_stop_busy", bus.busy, 0);
      chk("arm_stop_done", bus.done, 0);
      drain("arm_stop", 5);

      // start during RUN is ignored
      bus.m3r_stepLen = CNT_W'(5); bus.m3r_runSteps = RUN_W'(2);
      push_arm(); push_step(0, 5, 0); push_step(1, 5, 1); push_done(1);
      pulse_start();
      wait_at(0, 2, 20);
      #1 bus.start = 1'b1;
      @(posedge clk); #1 bus.start = 1'b0;
      drain("start_in_run", 50);

      // Asynchronous reset in step 5 of a continuous run
      bus.m3r_stepLen = CNT_W'(4); bus.m3r_runSteps = RUN_W'(0);
      push_arm();
      for (int i = 0; i < 5; i++) push_step(i, 4, 0);
      push_cycles(5, 4, 3, 2, 0);
      pulse_start();
      wait_at(5, 2, 100);
      #10 nRst = 1'b0;
      #1;
      chk_reset_vals("async_rst");
      drain("async_rst", 3);
      @(posedge clk); #1 nRst = 1'b1;
      @(posedge clk); #1;
      chk_reset_vals("after_rst");
      bus.m3r_runSteps = RUN_W'(2);
      push_arm(); push_step(0, 4, 0); push_step(1, 4, 1); push_done(1);
      pulse_start();
      drain("restart", 50);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
`default_nettype wire
